down_counter_timer: RTL



---
 rtl/down_counter_timer_pkg.sv | 13 +
 rtl/down_counter_timer_sync_t_ff.sv | 41 ++++
 rtl/down_counter_timer.sv | 114 +++++++++++
 3 files changed

// File: rtl/down_counter_timer_pkg.sv
// rtl/down_counter_timer_pkg.sv - shared state encodings and defaults for the down-counter timer
package down_counter_timer_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // 2'b11 is unused; the top recovers from it to IDLE on the next clock.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        EXPIRED = 2'b10
    } timer_state_e;

endpackage

// File: rtl/down_counter_timer_sync_t_ff.sv
// rtl/down_counter_timer_sync_t_ff.sv - T flip-flop with sync active-high clear and sync parallel load
//
// Ports:
//   clk_i    rising-edge clock
//   reset_i  synchronous active-high clear (highest priority)
//   load_i   synchronous load of d_i (beats toggle)
//   d_i      parallel load data
//   t_i      toggle enable
//   q_o      flip-flop state
module sync_t_ff (
    input  logic clk_i,
    input  logic reset_i,
    input  logic load_i,
    input  logic d_i,
    input  logic t_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = d_i;
        end else if (t_i) begin
            q_d = ~q_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - loadable down-counter / timer with one-shot or auto-reload expiry
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   load         capture load_value into count and reload register, start timer
//   load_value   value captured on load
//   enable       count-step qualifier
//   auto_reload  1 = reload on expiry and keep running, 0 = one-shot
//   count_out    current count
//   busy         high while in RUN
//   zero         combinational count_out == 0
//   done         registered one-cycle pulse on expiry
module down_counter_timer
    import down_counter_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count_out,
    output logic             busy,
    output logic             zero,
    output logic             done
);

    timer_state_e     state_q;
    logic [WIDTH-1:0] reload_q;
    logic             done_q;
    logic [WIDTH-1:0] count_q;

    logic             run_en;
    logic             step;
    logic             reload_now;
    logic             ff_load;
    logic [WIDTH-1:0] ff_data;
    logic [WIDTH-1:0] t;

    assign run_en = (state_q == RUN) && enable && !load;
    // A RUN state sitting at zero only happens after an auto-reload expiry;
    // the next enabled cycle restores the period instead of decrementing.
    assign reload_now = run_en && (count_q == '0);
    assign step       = run_en && (count_q != '0);
    assign ff_load    = load || reload_now;
    assign ff_data    = load ? load_value : reload_q;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            // Borrow chain: bit i flips when every lower bit is already zero.
            if (i == 0) begin : g_lsb
                assign t[i] = step;
            end else begin : g_upper
                assign t[i] = step && (count_q[i-1:0] == '0);
            end

            sync_t_ff u_tff (
                .clk_i   (clk),
                .reset_i (reset),
                .load_i  (ff_load),
                .d_i     (ff_data[i]),
                .t_i     (t[i]),
                .q_o     (count_q[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                reload_q <= load_value;
                if (load_value == '0) begin
                    // Zero-length timer: expire immediately, auto_reload ignored.
                    state_q <= EXPIRED;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= RUN;
                end
            end else begin
                case (state_q)
                    RUN: begin
                        if (enable && (count_q == WIDTH'(1))) begin
                            done_q <= 1'b1;
                            if (!auto_reload) begin
                                state_q <= EXPIRED;
                            end
                        end
                    end
                    IDLE, EXPIRED: begin
                        state_q <= state_q;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign count_out = count_q;
    assign busy      = (state_q == RUN);
    assign zero      = (count_q == '0);
    assign done      = done_q;

endmodule
